// File: rtl/min_pulse_shaper_pkg.sv
// Shared types and constants for the minimum-pulse-width shaper.
package min_pulse_shaper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } lane_state_t;

  localparam int unsigned TCOUNT_W   = 2;
  localparam logic [TCOUNT_W-1:0] TCOUNT_SAT = 2'd3;

  // Transition counter that sticks at TCOUNT_SAT instead of wrapping.
  function automatic logic [TCOUNT_W-1:0] sat_inc(input logic [TCOUNT_W-1:0] c,
                                                  input logic inc);
    if (inc && (c != TCOUNT_SAT)) return c + 2'd1;
    return c;
  endfunction

endpackage

// File: rtl/min_pulse_shaper_lane.sv
// One shaper lane: every output level is held for at least MIN_CYCLES clocks.
module min_pulse_shaper_lane
  import min_pulse_shaper_pkg::*;
#(
  parameter int MIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_dout,
  output logic o_busy,
  output logic o_ovf
);

  localparam int CNT_W = $clog2(MIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MIN_CYCLES - 1);

  lane_state_t         r_state, w_state;
  logic                r_dout, w_dout;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_pending, w_pending;
  logic [TCOUNT_W-1:0] r_tcount, w_tcount;
  logic                r_ovf, w_ovf;
  logic                r_din_prev;

  logic                w_din_edge;
  logic                w_diff;
  logic [TCOUNT_W-1:0] w_tcount_inc;

  assign w_din_edge   = (i_din != r_din_prev);
  assign w_diff       = (i_din != r_dout);
  assign w_tcount_inc = sat_inc(r_tcount, w_din_edge);

  always_comb begin
    w_state   = r_state;
    w_dout    = r_dout;
    w_cnt     = r_cnt;
    w_pending = r_pending;
    w_tcount  = r_tcount;
    w_ovf     = r_ovf;
    case (r_state)
      IDLE: begin
        if (w_diff) begin
          w_dout    = i_din;
          w_cnt     = RELOAD;
          w_pending = 1'b0;
          w_tcount  = '0;
          w_state   = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_cnt    = r_cnt - 1'b1;
          w_tcount = w_tcount_inc;
          if (w_diff) w_pending = 1'b1;
        end else begin
          // Eligible edge: the transition on this edge is counted before the overflow test.
          w_tcount = w_tcount_inc;
          if (w_tcount_inc >= TCOUNT_SAT) w_ovf = 1'b1;
          if (r_pending || w_diff) begin
            w_dout    = ~r_dout;
            w_cnt     = RELOAD;
            w_pending = 1'b0;
            w_tcount  = '0;
          end else begin
            w_state = IDLE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dout     <= 1'b0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_tcount   <= '0;
      r_ovf      <= 1'b0;
      r_din_prev <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_dout     <= w_dout;
      r_cnt      <= w_cnt;
      r_pending  <= w_pending;
      r_tcount   <= w_tcount;
      r_ovf      <= w_ovf;
      r_din_prev <= i_din;
    end
  end

  assign o_dout = r_dout;
  assign o_busy = (r_state == HOLD);
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/min_pulse_shaper.sv
// WIDTH independent minimum-pulse-width shaper lanes.
module min_pulse_shaper
  import min_pulse_shaper_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] ovf
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    min_pulse_shaper_lane #(
      .MIN_CYCLES(MIN_CYCLES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_din (din[g]),
      .o_dout(dout[g]),
      .o_busy(busy[g]),
      .o_ovf (ovf[g])
    );
  end

endmodule

// File: tb/tb_min_pulse_shaper.sv
// Directed bench for min_pulse_shaper: a MIN_CYCLES=3 instance and a MIN_CYCLES=1 instance.
module tb_min_pulse_shaper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic [3:0] dout, busy, ovf;
  logic [3:0] din2 = '0;
  logic [3:0] dout2, busy2, ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  min_pulse_shaper #(.WIDTH(4), .MIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .busy(busy), .ovf(ovf)
  );

  min_pulse_shaper #(.WIDTH(4), .MIN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .din(din2), .dout(dout2), .busy(busy2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int last_chg;
    int n_chg;
    logic prev3;
    logic [3:0] prev_din2;

    // Reset
    rst = 1'b1; din = '0; din2 = '0;
    tick(); tick();
    chk("rst_dout", dout, 4'h0);
    chk("rst_busy", busy, 4'h0);
    chk("rst_ovf",  ovf,  4'h0);
    chk("rst_dout1", dout2, 4'h0);
    rst = 1'b0;

    // Scenario A: edges 1..4 idle, lanes 0/1/2 stimulated from edge 5
    repeat (4) tick();
    chk("idle_dout", dout, 4'h0);
    din = 4'b0111; tick();                       // edge 5
    chk("e5_dout", dout, 4'b0111);
    chk("e5_busy", busy, 4'b0111);
    din = 4'b0010; tick();                       // edge 6
    chk("e6_dout", dout, 4'b0111);
    din = 4'b0110; tick();                       // edge 7
    chk("e7_dout", dout, 4'b0111);
    chk("e7_busy", busy, 4'b0111);
    chk("e7_ovf",  ovf,  4'b0000);
    din = 4'b0010; tick();                       // edge 8
    chk("e8_dout", dout, 4'b0010);
    chk("e8_busy", busy, 4'b0101);
    chk("e8_ovf",  ovf,  4'b0100);
    tick(); tick();                              // edges 9,10
    chk("e10_busy", busy, 4'b0101);
    tick();                                      // edge 11
    chk("e11_busy", busy, 4'b0000);
    chk("e11_dout", dout, 4'b0010);
    chk("e11_ovf",  ovf,  4'b0100);

    // Scenario B: lane 3 alternating every clock for 12 clocks, then held low
    last_chg = -100;
    n_chg = 0;
    prev3 = dout[3];
    for (int c = 1; c <= 24; c++) begin
      din = {((c <= 12) ? ((c % 2) == 1) : 1'b0), 3'b010};
      tick();
      if (dout[3] != prev3) begin
        chk("l3_spacing", ((c - last_chg) >= 3), 1'b1);
        last_chg = c;
        n_chg++;
      end
      prev3 = dout[3];
    end
    chk("l3_nchg", n_chg, 6);
    chk("l3_dout", dout, 4'b0010);
    chk("l3_ovf",  ovf,  4'b1100);
    chk("l3_busy", busy, 4'b0000);

    // Scenario C: reset abandons holds on all lanes
    din = 4'b0000; tick();
    din = 4'b1111; tick();
    chk("c_dout", dout, 4'b1101);
    rst = 1'b1; tick();
    chk("c_rst_dout", dout, 4'h0);
    chk("c_rst_busy", busy, 4'h0);
    chk("c_rst_ovf",  ovf,  4'h0);
    rst = 1'b0; tick();
    chk("c_rel_dout", dout, 4'b1111);
    chk("c_rel_busy", busy, 4'b1111);
    chk("c_rel_ovf",  ovf,  4'b0000);

    // Scenario D: MIN_CYCLES=1 instance is a one-clock delay
    for (int c = 0; c < 200; c++) begin
      prev_din2 = din2;
      din2 = 4'($urandom_range(0, 15));
      tick();
      chk("m1_dout", dout2, din2);
      chk("m1_ovf",  ovf2,  4'h0);
      if (c == 0) chk("m1_first", dout2, din2);
      if (c > 0 && prev_din2 == din2) chk("m1_hold", dout2, prev_din2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
